// File: rtl/blink_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : blink_sequencer
//  Description : Programmable tick/LED sequencer. A small table holds
//                (division, repeat-count) entries. Each entry produces
//                'count' ticks, one every div+1 cycles, and then the
//                sequence moves on to the next entry. The LED toggles on
//                every tick.
//  Ports       : clk, rst (async, active high)
//                cfg_we/cfg_addr/cfg_div/cfg_count : table write port
//                start/stop (pulses), loop          : sequence control
//                busy, tick, led, step_idx, done    : status outputs
//  Revision    : 1.0 - initial release
// ============================================================================
module blink_sequencer #(
    parameter int NSTEPS = 4,
    parameter int DIV_W  = 24,
    parameter int CNT_W  = 8,
    parameter int IDX_W  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_addr,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic             start,
    input  logic             stop,
    input  logic             loop,
    output logic             busy,
    output logic             tick,
    output logic             led,
    output logic [IDX_W-1:0] step_idx,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NSTEPS - 1);

    // ------------------------------------------------------------------
    // Step table
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] r_tbl_div [NSTEPS];
    logic [CNT_W-1:0] r_tbl_cnt [NSTEPS];
    logic             w_addr_ok;

    // Addresses beyond the populated table are dropped silently.
    assign w_addr_ok = ({{(32-IDX_W){1'b0}}, cfg_addr} < 32'(NSTEPS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NSTEPS; i++) begin
                r_tbl_div[i] <= '0;
                r_tbl_cnt[i] <= '0;
            end
        end else if (cfg_we && w_addr_ok) begin
            r_tbl_div[cfg_addr] <= cfg_div;
            r_tbl_cnt[cfg_addr] <= cfg_count;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    state_t           r_state,       w_state_nx;
    logic [IDX_W-1:0] r_step_idx,    w_step_nx;
    logic             r_pass_ticked, w_pass_nx;
    logic [DIV_W-1:0] r_counter,     w_counter_nx;
    logic [CNT_W-1:0] r_tick_cnt,    w_tick_cnt_nx;
    logic [DIV_W-1:0] r_cur_div,     w_cur_div_nx;
    logic [CNT_W-1:0] r_cur_cnt,     w_cur_cnt_nx;
    logic             r_tick,        w_tick_nx;
    logic             r_led,         w_led_nx;
    logic             w_advance;
    logic [CNT_W-1:0] w_tick_cnt_inc;

    assign w_tick_cnt_inc = r_tick_cnt + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_step_idx    <= '0;
            r_pass_ticked <= 1'b0;
            r_counter     <= '0;
            r_tick_cnt    <= '0;
            r_cur_div     <= '0;
            r_cur_cnt     <= '0;
            r_tick        <= 1'b0;
            r_led         <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_step_idx    <= w_step_nx;
            r_pass_ticked <= w_pass_nx;
            r_counter     <= w_counter_nx;
            r_tick_cnt    <= w_tick_cnt_nx;
            r_cur_div     <= w_cur_div_nx;
            r_cur_cnt     <= w_cur_cnt_nx;
            r_tick        <= w_tick_nx;
            r_led         <= w_led_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_step_nx     = r_step_idx;
        w_pass_nx     = r_pass_ticked;
        w_counter_nx  = r_counter;
        w_tick_cnt_nx = r_tick_cnt;
        w_cur_div_nx  = r_cur_div;
        w_cur_cnt_nx  = r_cur_cnt;
        w_tick_nx     = 1'b0;
        w_led_nx      = r_led;
        w_advance     = 1'b0;

        if (stop) begin
            // stop wins over start, ticks and advances. In IDLE it simply
            // masks a simultaneous start.
            if (r_state != S_IDLE) begin
                w_state_nx   = S_IDLE;
                w_step_nx    = '0;
                w_counter_nx = '0;
                w_led_nx     = 1'b0;
            end
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        w_state_nx = S_LOAD;
                        w_step_nx  = '0;
                        w_pass_nx  = 1'b0;
                        w_led_nx   = 1'b0;
                    end
                end
                S_LOAD: begin
                    w_cur_div_nx  = r_tbl_div[r_step_idx];
                    w_cur_cnt_nx  = r_tbl_cnt[r_step_idx];
                    w_counter_nx  = '0;
                    w_tick_cnt_nx = '0;
                    if (r_tbl_cnt[r_step_idx] != '0) begin
                        w_state_nx = S_RUN;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
                S_RUN: begin
                    if (r_counter == r_cur_div) begin
                        w_counter_nx  = '0;
                        w_tick_nx     = 1'b1;
                        w_led_nx      = ~r_led;
                        w_pass_nx     = 1'b1;
                        w_tick_cnt_nx = w_tick_cnt_inc;
                        if (w_tick_cnt_inc == r_cur_cnt) begin
                            w_advance = 1'b1;
                        end
                    end else begin
                        w_counter_nx = r_counter + DIV_W'(1);
                    end
                end
                default: begin
                    w_state_nx = S_IDLE;
                end
            endcase

            // w_pass_nx already includes a tick issued this very cycle, so
            // a pass whose only tick is the last one still counts as ticked.
            // Without that guard an all-skip table would spin forever.
            if (w_advance) begin
                if (r_step_idx != c_last_idx) begin
                    w_step_nx  = r_step_idx + IDX_W'(1);
                    w_state_nx = S_LOAD;
                end else if (loop && w_pass_nx) begin
                    w_step_nx  = '0;
                    w_pass_nx  = 1'b0;
                    w_state_nx = S_LOAD;
                end else begin
                    w_state_nx = S_DONE;
                end
            end
        end
    end

    assign busy     = (r_state == S_LOAD) || (r_state == S_RUN);
    assign done     = (r_state == S_DONE);
    assign tick     = r_tick;
    assign led      = r_led;
    assign step_idx = r_step_idx;

endmodule
`default_nettype wire

// File: tb/tb_blink_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_blink_sequencer
//  Description : Self-checking bench for blink_sequencer. Stimulus pushes the
//                expected (edge, led, step_idx) of every tick into a queue;
//                a monitor pops one entry per observed tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_blink_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [23:0] cfg_div;
    logic [7:0]  cfg_count;
    logic        start;
    logic        stop;
    logic        loop;
    logic        busy;
    logic        tick;
    logic        led;
    logic [1:0]  step_idx;
    logic        done;

    blink_sequencer #(
        .NSTEPS (4),
        .DIV_W  (24),
        .CNT_W  (8),
        .IDX_W  (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_div   (cfg_div),
        .cfg_count (cfg_count),
        .start     (start),
        .stop      (stop),
        .loop      (loop),
        .busy      (busy),
        .tick      (tick),
        .led       (led),
        .step_idx  (step_idx),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far; a tick launched by edge N is
    // observed at the falling edge where cyc == N.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         edge_no;
        logic       led;
        logic [1:0] step;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input int e, input logic l, input logic [1:0] s);
        exp_t x;
        x.edge_no = e;
        x.led     = l;
        x.step    = s;
        q.push_back(x);
    endtask

    // Monitor: every tick must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && tick) begin
            chk("tick_expected", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) begin
                m_e = q.pop_front();
                chk("tick_edge", cyc, m_e.edge_no);
                chk("tick_led",  32'(led), 32'(m_e.led));
                chk("tick_step", 32'(step_idx), 32'(m_e.step));
            end
        end
    end

    // Return at the falling edge right before edge e (inputs set now are
    // sampled by edge e).
    task automatic go_edge(input int e);
        while (cyc < e - 1) @(negedge clk);
    endtask

    // Return at the falling edge right after edge e.
    task automatic after_edge(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input int d, input int c);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_div   = 24'(d);
        cfg_count = 8'(c);
        @(negedge clk);
        cfg_we    = 1'b0;
    endtask

    // Pulse start; returns E0, the edge that samples it.
    task automatic pulse_start(output int e0);
        e0    = cyc + 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_stop_at(input int e);
        go_edge(e);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got edge %0d expected finish", cyc);
        $fatal(1, "watchdog");
    end

    int e0;
    int e1;

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_div = '0; cfg_count = '0;
        start = 1'b0; stop = 1'b0; loop = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Quiet after reset.
        repeat (20) begin
            @(negedge clk);
            chk("idle_outputs", 32'({tick, led, busy, done, step_idx}), 32'd0);
        end

        // Fast-fast / burst / skip / single, no looping.
        wr(2'd0, 3, 2); wr(2'd1, 0, 3); wr(2'd2, 1, 0); wr(2'd3, 2, 1);
        loop = 1'b0;
        pulse_start(e0); e1 = e0 + 1;
        push(e1+4, 1'b1, 2'd0); push(e1+8, 1'b0, 2'd1); push(e1+10, 1'b1, 2'd1);
        push(e1+11, 1'b0, 2'd1); push(e1+12, 1'b1, 2'd2); push(e1+17, 1'b0, 2'd3);
        after_edge(e0);
        chk("a_busy_load", 32'(busy), 32'd1);
        after_edge(e1+13);
        chk("a_skip_step2", 32'(step_idx), 32'd3);
        after_edge(e1+17);
        chk("a_done", 32'({done, busy}), 32'b10);
        chk("a_led_end", 32'(led), 32'd0);
        after_edge(e1+18);
        chk("a_done_hold", 32'({done, tick}), 32'b10);
        chk("a_queue_empty", 32'(q.size()), 32'd0);

        // Same table, looping: two identical passes, then stop.
        loop = 1'b1;
        pulse_start(e0); e1 = e0 + 1;
        for (int k = 0; k < 2; k++) begin
            push(e1+18*k+4,  1'b1, 2'd0); push(e1+18*k+8,  1'b0, 2'd1);
            push(e1+18*k+10, 1'b1, 2'd1); push(e1+18*k+11, 1'b0, 2'd1);
            push(e1+18*k+12, 1'b1, 2'd2); push(e1+18*k+17, 1'b0, 2'd0);
        end
        after_edge(e1+17);
        chk("b_wrap_step", 32'(step_idx), 32'd0);
        chk("b_not_done", 32'({done, busy}), 32'b01);
        after_edge(e1+37);
        chk("b_still_running", 32'({done, busy}), 32'b01);
        pulse_stop_at(e1+38);
        chk("b_stopped", 32'({done, busy, step_idx}), 32'd0);
        chk("b_queue_empty", 32'(q.size()), 32'd0);

        // stop coinciding with the second scheduled tick of step 0.
        loop = 1'b0;
        pulse_start(e0); e1 = e0 + 1;
        push(e1+4, 1'b1, 2'd0);
        after_edge(e1+7);
        chk("c_led_before_stop", 32'(led), 32'd1);
        pulse_stop_at(e1+8);
        chk("c_stop_clears", 32'({tick, led, busy, done, step_idx}), 32'd0);
        repeat (8) @(negedge clk);
        chk("c_queue_empty", 32'(q.size()), 32'd0);
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        chk("c_start_stop_idle", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        chk("c_still_idle", 32'({busy, done}), 32'd0);

        // All counts zero with loop=1: one pass of LOADs then DONE.
        wr(2'd0, 0, 0); wr(2'd1, 0, 0); wr(2'd2, 0, 0); wr(2'd3, 0, 0);
        loop = 1'b1;
        pulse_start(e0);
        after_edge(e0+3);
        chk("d_load_step3", 32'({busy, done, step_idx}), 32'b1011);
        after_edge(e0+4);
        chk("d_done", 32'({busy, done, step_idx}), 32'b0111);
        repeat (5) @(negedge clk);
        chk("d_done_hold", 32'({busy, done}), 32'b01);

        // Rewrite entry 0 while step 1 runs: old value this pass, new next.
        wr(2'd0, 1, 1); wr(2'd1, 2, 1);
        pulse_start(e0); e1 = e0 + 1;
        push(e1+2, 1'b1, 2'd1); push(e1+6, 1'b0, 2'd2);
        push(e1+15, 1'b1, 2'd1); push(e1+19, 1'b0, 2'd2);
        go_edge(e1+4);
        chk("e_in_step1", 32'(step_idx), 32'd1);
        wr(2'd0, 5, 1);
        pulse_stop_at(e1+24);
        chk("e_stopped", 32'(busy), 32'd0);
        chk("e_queue_empty", 32'(q.size()), 32'd0);

        // Asynchronous reset in the middle of a run.
        wr(2'd0, 0, 5);
        loop = 1'b0;
        pulse_start(e0); e1 = e0 + 1;
        push(e1+1, 1'b1, 2'd0); push(e1+2, 1'b0, 2'd0);
        go_edge(e1+3);
        @(posedge clk);
        #3;
        chk("f_tick_before_rst", 32'({tick, led}), 32'b11);
        rst = 1'b1;
        #1;
        chk("f_async_rst", 32'({tick, led, busy, done, step_idx}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("f_queue_empty", 32'(q.size()), 32'd0);
        pulse_start(e0);
        after_edge(e0+3);
        chk("f_cleared_tbl_load", 32'({busy, done, step_idx}), 32'b1011);
        after_edge(e0+4);
        chk("f_cleared_tbl_done", 32'({busy, done}), 32'b01);
        repeat (4) @(negedge clk);
        chk("final_queue_empty", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/blink_sequencer.md
Name: blink_sequencer

Overview:
- Programmable tick/LED sequencer that owns a clock-divider counter and steps it through a small table of (division, repeat-count) entries.
- Each step emits a fixed number of divided ticks, then advances to the next entry, giving blink patterns such as fast-fast-slow.
- Sits between the board clock and LED/peripheral logic.
- Configured by a simple write port; controlled by start/stop.

Parameters:
- NSTEPS, 4, number of table entries (2..16)
- DIV_W, 24, width of division factor
- CNT_W, 8, width of per-step tick repeat count
- IDX_W, 2, width of step index; must equal clog2(NSTEPS)

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- cfg_we  input  1  table write strobe
- cfg_addr  input  IDX_W  table entry to write
- cfg_div  input  DIV_W  division factor for entry; tick period = cfg_div+1 cycles
- cfg_count  input  CNT_W  ticks emitted in entry; 0 = skip entry
- start  input  1  begin sequence from step 0 (pulse)
- stop  input  1  abort to IDLE (pulse)
- loop  input  1  1 = wrap to step 0 after last step; 0 = finish
- busy  output  1  high in LOAD or RUN
- tick  output  1  one-cycle pulse per divided period
- led  output  1  toggles on every tick
- step_idx  output  IDX_W  current step
- done  output  1  high while in DONE

Behaviour:
- Reset (async, rst=1): state IDLE; all table entries div=0, count=0; counter=0, tick_cnt=0, step_idx=0, tick=0, led=0, done=0, busy=0; pass_ticked=0.
- Table writes: accepted in every state at the clock edge when cfg_we=1. An entry is latched into cur_div/cur_cnt only in LOAD, so a write to the running step takes effect the next time that step loads.
- Table size: cfg_addr >= NSTEPS is ignored.
- States: IDLE, LOAD, RUN, DONE.
- IDLE: start=1 -> LOAD with step_idx=0, pass_ticked=0, led=0.
- LOAD (one cycle): latch cur_div, cur_cnt from table[step_idx]; counter<=0, tick_cnt<=0.
  - cur_cnt != 0 -> RUN.
  - cur_cnt == 0 -> advance (see Advance).
- RUN: counter increments each cycle. When counter==cur_div:
  - counter<=0, tick<=1 next cycle, led<=~led, pass_ticked<=1, tick_cnt<=tick_cnt+1.
  - If tick_cnt+1==cur_cnt -> Advance.
- Advance:
  - step_idx<NSTEPS-1 -> step_idx+1, LOAD.
  - Last step, loop=1 and pass_ticked=1 -> step_idx=0, pass_ticked=0, LOAD.
  - Last step, otherwise -> DONE.
  - loop is sampled only at this point.
  - An all-zero-count table therefore reaches DONE after one pass with no ticks, even with loop=1.
- Timing:
  - Start sampled at edge E0 -> LOAD after E0, RUN after E1 with counter=0.
  - First tick is high during the cycle after edge E1+cur_div+1.
  - Tick period within a step = cur_div+1 cycles.
  - Each step transition inserts exactly one LOAD cycle, so the interval across a boundary = 1 + (next div+1).
  - cur_div=0 -> tick every cycle during RUN.
- tick: registered; never high two cycles in a row unless cur_div=0; always 0 in IDLE and DONE except the final tick's cycle.
- DONE: done=1, led holds its value. start -> LOAD at step 0 (done drops). stop -> IDLE.
- stop: from LOAD, RUN or DONE -> IDLE next edge. Clears tick, led, done, step_idx, counter. stop has priority over start and over any tick/advance in the same cycle. start while busy is ignored.
- Width rules:
  - counter is DIV_W bits and compared with ==, so it never wraps past cur_div.
  - tick_cnt is CNT_W bits; cur_cnt=2^CNT_W-1 is valid.
- Reset asserted mid-sequence: immediate return to reset values, including table clear.

Test Plan:
- Reset then idle 20 cycles -> tick=0, led=0, busy=0, done=0, step_idx=0 throughout.
- Table {(div=3,cnt=2),(div=0,cnt=3),(div=1,cnt=0),(div=2,cnt=1)}, loop=0, start:
  - ticks at cycles E1+5, +9, then one LOAD gap, then 3 consecutive ticks, step 2 skipped, 1 tick 3 cycles after the step-3 RUN entry.
  - done=1 after it; led ends at 0 (6 toggles).
- Same table, loop=1 -> step_idx wraps 3->0; tick sequence repeats identically; done stays 0.
- stop asserted in the same cycle as a scheduled tick in RUN -> no tick; IDLE next cycle, led=0. start and stop together in IDLE -> stays IDLE.
- All counts 0, loop=1, start -> LOAD x4 then DONE, zero ticks. Rewrite entry 0 (div=5,cnt=1) during step 1 of a run -> new value used only on the next pass.
- Assert rst asynchronously mid-RUN (between edges) -> outputs zero immediately. Next start with an unwritten table -> DONE after 4 LOAD cycles, no ticks.
